uart_frame_sequencer: RTL and testbench

UART_FRAME_SEQUENCER -- requirements
Module: uart_frame_sequencer

---
 rtl/uart_frame_sequencer.sv | 137 +++++++++++++
 tb/tb_uart_frame_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sequencer.sv
// UART frame sequencer: walks START, DATA, optional PARITY and STOP bit slots,
// counting OVS oversample ticks per bit and emitting registered timing pulses.
module uart_frame_sequencer #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned OVS       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic [2:0] bit_type,
    output logic [3:0] bit_index,
    output logic       sample,
    output logic       bit_end,
    output logic       frame_done,
    output logic       aborted
);

    localparam int unsigned CW = $clog2(OVS);
    localparam logic [CW-1:0] CntMax  = CW'(OVS - 1);
    localparam logic [CW-1:0] CntHalf = CW'(OVS / 2 - 1);
    localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);

    // Encodings double as the bit_type output value.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic          busy_d, sample_d, bit_end_d, frame_done_d, aborted_d;

    // Next-state and next-output decode; abort outranks tick, and outranks start when idle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        busy_d       = busy;
        sample_d     = 1'b0;
        bit_end_d    = 1'b0;
        frame_done_d = 1'b0;
        aborted_d    = 1'b0;
        if (state_q == StIdle) begin
            if (start && !abort) begin
                state_d = StStart;
                cnt_d   = '0;
                idx_d   = '0;
                busy_d  = 1'b1;
            end
        end else if (abort) begin
            state_d   = StIdle;
            cnt_d     = '0;
            idx_d     = '0;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
        end else if (tick) begin
            if (cnt_q == CntMax) begin
                cnt_d     = '0;
                bit_end_d = 1'b1;
                case (state_q)
                    StStart: begin
                        state_d = StData;
                        idx_d   = '0;
                    end
                    StData: begin
                        if (idx_q == LastData) begin
                            idx_d   = '0;
                            state_d = (PARITY_EN != 0) ? StParity : StStop;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                    StParity: begin
                        state_d = StStop;
                        idx_d   = '0;
                    end
                    StStop: begin
                        if (idx_q == LastStop) begin
                            state_d      = StIdle;
                            idx_d        = '0;
                            busy_d       = 1'b0;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
                // Mid-bit: the tick that lands on OVS/2.
                if (cnt_q == CntHalf) begin
                    sample_d = 1'b1;
                end
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            busy       <= 1'b0;
            sample     <= 1'b0;
            bit_end    <= 1'b0;
            frame_done <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            busy       <= busy_d;
            sample     <= sample_d;
            bit_end    <= bit_end_d;
            frame_done <= frame_done_d;
            aborted    <= aborted_d;
        end
    end

    assign bit_type  = state_q;
    assign bit_index = idx_q;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Directed bench for uart_frame_sequencer: default config plus a 7N2 instance.
module tb_uart_frame_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic start2 = 1'b0;
    logic abort2 = 1'b0;

    logic       busy, sample, bit_end, frame_done, aborted;
    logic [2:0] bit_type;
    logic [3:0] bit_index;
    logic       busy2, sample2, bit_end2, frame_done2, aborted2;
    logic [2:0] bit_type2;
    logic [3:0] bit_index2;

    int total = 0;
    int bad   = 0;

    // Per-run observation counters.
    int         ns, nb, nd, na, first_s, done_t;
    logic       done_busy, done_be;
    logic [2:0] done_bt;
    logic [2:0] seq_t [16];
    logic [3:0] seq_i [16];

    uart_frame_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .bit_type   (bit_type),
        .bit_index  (bit_index),
        .sample     (sample),
        .bit_end    (bit_end),
        .frame_done (frame_done),
        .aborted    (aborted)
    );

    uart_frame_sequencer #(
        .DATA_BITS (7),
        .PARITY_EN (0),
        .STOP_BITS (2),
        .OVS       (16)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start      (start2),
        .abort      (abort2),
        .busy       (busy2),
        .bit_type   (bit_type2),
        .bit_index  (bit_index2),
        .sample     (sample2),
        .bit_end    (bit_end2),
        .frame_done (frame_done2),
        .aborted    (aborted2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        ns = 0; nb = 0; nd = 0; na = 0; first_s = -1; done_t = -1;
        done_busy = 1'bx; done_be = 1'bx; done_bt = 3'bxxx;
        for (int i = 0; i < 16; i++) begin
            seq_t[i] = 3'd7;
            seq_i[i] = 4'd15;
        end
    endtask

    task automatic observe(input int t, input bit sel);
        logic s, b, d, a;
        logic [2:0] bt;
        logic [3:0] bi;
        s  = sel ? sample2 : sample;
        b  = sel ? bit_end2 : bit_end;
        d  = sel ? frame_done2 : frame_done;
        a  = sel ? aborted2 : aborted;
        bt = sel ? bit_type2 : bit_type;
        bi = sel ? bit_index2 : bit_index;
        if (s) begin
            if (ns < 16) begin
                seq_t[ns] = bt;
                seq_i[ns] = bi;
            end
            if (first_s < 0) first_s = t;
            ns++;
        end
        if (b) nb++;
        if (a) na++;
        if (d) begin
            nd++;
            done_t    = t;
            done_busy = sel ? busy2 : busy;
            done_be   = b;
            done_bt   = bt;
        end
    endtask

    // n ticks spaced 'gap' clocks; start is raised together with ticks sa/sb/sc.
    task automatic run_ticks(input int n, input int gap, input bit sel,
                             input int sa, input int sb, input int sc);
        clear_counts();
        for (int t = 1; t <= n; t++) begin
            start = (t == sa || t == sb || t == sc);
            tick  = 1'b1;
            step();
            tick  = 1'b0;
            start = 1'b0;
            observe(t, sel);
            for (int g = 1; g < gap; g++) begin
                step();
                observe(t, sel);
            end
        end
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL launch_busy got=%b exp=1", busy); end
        total++; if (bit_type !== 3'd1) begin bad++; $display("FAIL launch_type got=%0d exp=1", bit_type); end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        tick  = 1'b1;
        abort = 1'b1;
        step();
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (bit_type !== 3'd0) begin bad++; $display("FAIL rst_type got=%0d exp=0", bit_type); end
        total++; if (bit_index !== 4'd0) begin bad++; $display("FAIL rst_index got=%0d exp=0", bit_index); end
        total++; if ({sample, bit_end, frame_done, aborted} !== 4'b0) begin
            bad++; $display("FAIL rst_pulses got=%b exp=0000", {sample, bit_end, frame_done, aborted});
        end
        total++; if ({busy2, bit_type2} !== 4'b0) begin bad++; $display("FAIL rst_dut2 got=%b exp=0", {busy2, bit_type2}); end
        tick  = 1'b0;
        abort = 1'b0;
        rst   = 1'b1;
        step();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_first_start got=%b exp=1", busy); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++; if (aborted !== 1'b1) begin bad++; $display("FAIL rst_abort got=%b exp=1", aborted); end
        step();
    endtask

    task automatic test_default_frame();
        logic [2:0] exp_t [11] = '{1, 2, 2, 2, 2, 2, 2, 2, 2, 3, 4};
        logic [3:0] exp_i [11] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 0, 0};
        launch();
        run_ticks(176, 4, 1'b0, 0, 0, 0);
        total++; if (ns !== 11) begin bad++; $display("FAIL dflt_samples got=%0d exp=11", ns); end
        total++; if (first_s !== 8) begin bad++; $display("FAIL dflt_first_sample got=%0d exp=8", first_s); end
        total++; if (nb !== 11) begin bad++; $display("FAIL dflt_bit_ends got=%0d exp=11", nb); end
        total++; if (nd !== 1) begin bad++; $display("FAIL dflt_done_count got=%0d exp=1", nd); end
        total++; if (done_t !== 176) begin bad++; $display("FAIL dflt_done_tick got=%0d exp=176", done_t); end
        total++; if ({done_busy, done_be, done_bt} !== 5'b01000) begin
            bad++; $display("FAIL dflt_done_cycle got=%b exp=01000", {done_busy, done_be, done_bt});
        end
        total++; if (na !== 0) begin bad++; $display("FAIL dflt_aborted got=%0d exp=0", na); end
        for (int i = 0; i < 11; i++) begin
            total++;
            if (seq_t[i] !== exp_t[i] || seq_i[i] !== exp_i[i]) begin
                bad++;
                $display("FAIL dflt_seq[%0d] got=%0d/%0d exp=%0d/%0d", i, seq_t[i], seq_i[i], exp_t[i], exp_i[i]);
            end
        end
    endtask

    task automatic test_7n2();
        logic [2:0] exp_t [10] = '{1, 2, 2, 2, 2, 2, 2, 2, 4, 4};
        logic [3:0] exp_i [10] = '{0, 0, 1, 2, 3, 4, 5, 6, 0, 1};
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL c2_busy got=%b exp=1", busy2); end
        run_ticks(160, 4, 1'b1, 0, 0, 0);
        total++; if (done_t !== 160) begin bad++; $display("FAIL c2_done_tick got=%0d exp=160", done_t); end
        total++; if (nd !== 1) begin bad++; $display("FAIL c2_done_count got=%0d exp=1", nd); end
        total++; if (ns !== 10) begin bad++; $display("FAIL c2_samples got=%0d exp=10", ns); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (seq_t[i] !== exp_t[i] || seq_i[i] !== exp_i[i]) begin
                bad++;
                $display("FAIL c2_seq[%0d] got=%0d/%0d exp=%0d/%0d", i, seq_t[i], seq_i[i], exp_t[i], exp_i[i]);
            end
        end
    endtask

    task automatic test_abort();
        launch();
        // 71 ticks: DATA index 3, sub-bit count 7, so a coincident tick would sample.
        run_ticks(71, 4, 1'b0, 0, 0, 0);
        total++; if (bit_type !== 3'd2 || bit_index !== 4'd3) begin
            bad++; $display("FAIL abort_pre got=%0d/%0d exp=2/3", bit_type, bit_index);
        end
        abort = 1'b1;
        tick  = 1'b1;
        step();
        abort = 1'b0;
        tick  = 1'b0;
        total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort_pulse got=%b exp=1", aborted); end
        total++; if ({busy, bit_type, bit_index} !== 8'b0) begin
            bad++; $display("FAIL abort_state got=%b exp=0", {busy, bit_type, bit_index});
        end
        total++; if ({sample, bit_end, frame_done} !== 3'b0) begin
            bad++; $display("FAIL abort_pulses got=%b exp=000", {sample, bit_end, frame_done});
        end
        step();
        total++; if (aborted !== 1'b0) begin bad++; $display("FAIL abort_one_cycle got=%b exp=0", aborted); end
        // Idle abort beats a coincident start and produces no aborted pulse.
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        total++; if ({busy, aborted} !== 2'b00) begin bad++; $display("FAIL abort_idle got=%b exp=00", {busy, aborted}); end
        launch();
        run_ticks(176, 4, 1'b0, 0, 0, 0);
        total++; if (done_t !== 176 || nd !== 1) begin
            bad++; $display("FAIL abort_refill got=%0d/%0d exp=176/1", done_t, nd);
        end
    endtask

    task automatic test_ignored_starts();
        launch();
        run_ticks(175, 4, 1'b0, 50, 175, 0);
        total++; if (nd !== 0 || busy !== 1'b1 || bit_type !== 3'd4) begin
            bad++; $display("FAIL ign_pre got=%0d/%b/%0d exp=0/1/4", nd, busy, bit_type);
        end
        tick  = 1'b1;
        start = 1'b1;
        step();
        tick  = 1'b0;
        start = 1'b0;
        total++; if ({frame_done, busy, bit_type} !== 5'b10000) begin
            bad++; $display("FAIL ign_final got=%b exp=10000", {frame_done, busy, bit_type});
        end
        // Start in the frame_done cycle is taken.
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (busy !== 1'b1 || bit_type !== 3'd1) begin
            bad++; $display("FAIL ign_done_start got=%b/%0d exp=1/1", busy, bit_type);
        end
        run_ticks(176, 4, 1'b0, 0, 0, 0);
        total++; if (done_t !== 176) begin bad++; $display("FAIL ign_next_done got=%0d exp=176", done_t); end
    endtask

    task automatic test_reset_mid();
        launch();
        run_ticks(99, 4, 1'b0, 0, 0, 0);
        rst  = 1'b0;
        tick = 1'b1;
        step();
        rst  = 1'b1;
        tick = 1'b0;
        total++; if ({busy, bit_type, bit_index, sample, bit_end, frame_done, aborted} !== 12'b0) begin
            bad++; $display("FAIL rmid_outputs got=%b exp=0",
                            {busy, bit_type, bit_index, sample, bit_end, frame_done, aborted});
        end
        run_ticks(20, 4, 1'b0, 0, 0, 0);
        total++; if (ns + nb + nd + na !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL rmid_idle_ticks got=%0d/%b exp=0/0", ns + nb + nd + na, busy);
        end
        launch();
        run_ticks(176, 4, 1'b0, 0, 0, 0);
        total++; if (done_t !== 176 || ns !== 11) begin
            bad++; $display("FAIL rmid_next got=%0d/%0d exp=176/11", done_t, ns);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        tick = 1'b1;
        for (int rep = 0; rep < 3; rep++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy[%0d] got=%b exp=1", rep, busy); end
            c = -1;
            for (int k = 1; k <= 300; k++) begin
                step();
                if (frame_done) begin
                    c = k;
                    break;
                end
            end
            total++; if (c !== 176) begin bad++; $display("FAIL b2b_len[%0d] got=%0d exp=176", rep, c); end
        end
        tick = 1'b0;
        step();
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_default_frame();
        test_7n2();
        test_abort();
        test_ignored_starts();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
